fetch_sequencer: RTL and testbench

Drives the program counter and instruction-memory fetch handshake for the core front end. It issues one request at a time to instruction memory, tracks the outstanding request, and presents fetched instructions to decode through a registered valid/stall interface. It applies control-flow redirects from execute, such as taken branches and JAL/JALR targets, by flushing fetched and in-flight instructions.

---
 rtl/fetch_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Front-end fetch control. Keeps the next fetch PC, issues one instruction
// memory request at a time, and hands fetched instructions to decode through
// a registered valid/stall slot. A one-entry skid buffer catches a response
// that arrives while decode is stalled. Execute redirects flush the slot and
// the skid buffer. They also kill any response still in flight.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   redirect_valid/pc   taken branch / jump target from execute
//   stall               decode cannot accept; if_* held
//   imem_req/addr       fetch request and word address (addr = pc_q)
//   imem_gnt            request accepted this cycle
//   imem_rvalid/rdata   fetch response
//   if_valid/pc/instr   instruction presented to decode
//   misalign            one-cycle pulse after a misaligned redirect
//
// Build option
//   MISALIGN_TRAP_EN    when defined, a redirect whose target is not word
//                       aligned fetches from TRAP_VECTOR and pulses misalign.
//                       When undefined, the low target bits are dropped and
//                       misalign is tied low.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        skid_v_q, skid_v_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;

    logic [31:0] redir_tgt;
    logic        redir_mis;
    logic        grant;
    logic        resp_fire;
    logic        resp_ok;
    logic        slot_free;

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;

    always_comb begin
        redir_mis = (redirect_pc[1:0] != 2'b00);
        redir_tgt = redir_mis ? TRAP_VECTOR : redirect_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_valid && redir_mis;
        end
    end

    assign misalign = misalign_q;
`else
    logic unused_cfg;

    assign redir_mis  = 1'b0;
    assign redir_tgt  = {redirect_pc[31:2], 2'b00};
    assign misalign   = 1'b0;
    assign unused_cfg = ^{TRAP_VECTOR, redirect_pc[1:0], redir_mis};
`endif

    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;

    // Only a response that arrives while waiting counts; late data seen in
    // IDLE/REQ (e.g. from a transaction abandoned by reset) is ignored.
    assign resp_fire = (state_q == WAIT) && imem_rvalid;
    assign resp_ok   = resp_fire && !kill_q;
    assign slot_free = !if_valid_q || !stall;
    assign grant     = imem_req && imem_gnt;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        skid_v_d     = skid_v_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        req_pc_d     = req_pc_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        imem_req     = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                // Hold off new requests while the skid buffer is occupied so
                // at most two instructions are ever buffered.
                imem_req = !skid_v_q;
                if (grant) begin
                    state_d  = WAIT;
                    pc_d     = pc_q + 32'd4;
                    req_pc_d = pc_q;
                end
            end
            WAIT: begin
                if (resp_fire) begin
                    state_d = REQ;
                    kill_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Output slot: skid is always older than a response in the same cycle.
        if (slot_free) begin
            if (skid_v_q) begin
                if_valid_d = 1'b1;
                if_pc_d    = skid_pc_q;
                if_instr_d = skid_instr_q;
                skid_v_d   = 1'b0;
                if (resp_ok) begin
                    skid_v_d     = 1'b1;
                    skid_pc_d    = req_pc_q;
                    skid_instr_d = imem_rdata;
                end
            end else if (resp_ok) begin
                if_valid_d = 1'b1;
                if_pc_d    = req_pc_q;
                if_instr_d = imem_rdata;
            end else begin
                if_valid_d = 1'b0;
                if_instr_d = NOP_INSTR;
            end
        end else if (resp_ok) begin
            skid_v_d     = 1'b1;
            skid_pc_d    = req_pc_q;
            skid_instr_d = imem_rdata;
        end

        // Redirect wins over stall and responses.
        if (redirect_valid) begin
            pc_d       = redir_tgt;
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
            skid_v_d   = 1'b0;
            case (state_q)
                WAIT: begin
                    // A response landing this very cycle retires the old
                    // request, so nothing is left to kill.
                    state_d = resp_fire ? REQ : WAIT;
                    kill_d  = !resp_fire;
                end
                REQ: begin
                    if (grant) begin
                        state_d = WAIT;
                        kill_d  = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    // Control and decode-visible state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VECTOR;
            kill_q     <= 1'b0;
            skid_v_q   <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0000_0000;
            if_instr_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            skid_v_q   <= skid_v_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    // Datapath holding registers, qualified by the control state above
    always_ff @(posedge clk) begin
        req_pc_q     <= req_pc_d;
        skid_pc_q    <= skid_pc_d;
        skid_instr_q <= skid_instr_d;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam logic [31:0] TRAP = 32'h0000_0100;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] XORK = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    // memory model knobs
    int gnt_pct = 100;
    int lat_min = 1;
    int lat_max = 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .misalign      (misalign)
    );

    task automatic chk(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(name, act === exp, act, exp);
    endtask

    // Where fetch continues after a redirect to t.
    function automatic logic [31:0] exp_target(input logic [31:0] t);
        logic [1:0] lo;
        lo = t[1:0];
`ifdef MISALIGN_TRAP_EN
        return (lo != 2'b00) ? TRAP : t;
`else
        return (lo != 2'b00) ? (t - 32'(lo)) : t;
`endif
    endfunction

    // Decode must see the straight-line stream start, start+4, ... (mod 2^32).
    task automatic load_stream(input logic [31:0] start);
        exp_t e;
        exp_q.delete();
        for (int k = 0; k < 200; k++) begin
            e.pc    = start + 32'(4 * k);
            e.instr = e.pc ^ XORK;
            exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(input string name, output logic [31:0] addr);
        bit seen;
        seen = 1'b0;
        addr = '0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (imem_req && imem_gnt) begin
                seen = 1'b1;
                addr = imem_addr;
            end
        end
        chk(name, seen, 32'(seen), 32'd1);
    endtask

    task automatic wait_valid_pc(input string name, input logic [31:0] pc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (if_valid) seen = 1'b1;
        end
        if (seen) chk_eq(name, if_pc, pc);
        else      chk(name, 1'b0, 32'h0, pc);
    endtask

    // Instruction memory: random grant, one response per grant after
    // lat_min..lat_max cycles, rdata = addr ^ XORK.
    bit          pend;
    logic [31:0] pend_a;
    int          pend_d;

    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pend        = 1'b0;
        pend_a      = 32'h0;
        pend_d      = 0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
            if (rst) begin
                pend     = 1'b0;
                imem_gnt = 1'b0;
            end else begin
                if (pend) begin
                    if (pend_d <= 1) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = pend_a ^ XORK;
                        pend        = 1'b0;
                    end else begin
                        pend_d--;
                    end
                end
                imem_gnt = ($urandom_range(99) < gnt_pct);
                if (imem_req && imem_gnt) begin
                    chk("one_outstanding", !pend, 32'(pend), 32'd0);
                    pend   = 1'b1;
                    pend_a = imem_addr;
                    pend_d = $urandom_range(lat_max, lat_min);
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic        p_rst;
        logic        p_redir;
        logic        p_mis;
        logic        p_hold;
        logic [31:0] p_pc;
        logic [31:0] p_instr;
        exp_t        e;
        p_rst = 1'b0; p_redir = 1'b0; p_mis = 1'b0; p_hold = 1'b0;
        p_pc = 32'h0; p_instr = 32'h0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (p_rst) begin
                chk_eq("rst_if_valid", if_valid, 1'b0);
                chk_eq("rst_if_pc", if_pc, 32'h0);
                chk_eq("rst_if_instr", if_instr, NOP);
                chk_eq("rst_imem_req", imem_req, 1'b0);
                chk_eq("rst_misalign", misalign, 1'b0);
            end
            if (p_redir && !p_rst) begin
                chk_eq("flush_if_valid", if_valid, 1'b0);
                chk_eq("flush_if_instr", if_instr, NOP);
            end
            if (p_hold) begin
                chk_eq("stall_hold_valid", if_valid, 1'b1);
                chk_eq("stall_hold_pc", if_pc, p_pc);
                chk_eq("stall_hold_instr", if_instr, p_instr);
            end
`ifdef MISALIGN_TRAP_EN
            chk_eq("misalign", misalign, p_mis);
`else
            chk_eq("misalign", misalign, 1'b0);
`endif
            if (!if_valid) chk_eq("idle_nop", if_instr, NOP);
            if (!rst && !redirect_valid && if_valid && !stall) begin
                if (exp_q.size() == 0) begin
                    chk("stream_empty", 1'b0, if_pc, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk_eq("if_pc", if_pc, e.pc);
                    chk_eq("if_instr", if_instr, e.instr);
                end
            end
            p_rst   = rst;
            p_redir = redirect_valid;
            p_mis   = redirect_valid && !rst && (redirect_pc[1:0] != 2'b00);
            p_hold  = if_valid && stall && !redirect_valid && !rst;
            p_pc    = if_pc;
            p_instr = if_instr;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        load_stream(exp_target(pc));
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        int          first_k;
        int          since;
        int          r;
        logic [31:0] ga;

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
        load_stream(RV);
        repeat (3) step();
        rst = 1'b0;

        // first request one cycle after reset, first valid three cycles after
        first_k = -1;
        for (int k = 0; k <= 8 && first_k < 0; k++) begin
            @(negedge clk);
            #1;
            if (k == 1) begin
                chk_eq("first_req", imem_req, 1'b1);
                chk_eq("first_addr", imem_addr, RV);
            end
            if (if_valid) first_k = k;
        end
        chk("first_valid_latency", first_k == 3, 32'(first_k), 32'd3);

        repeat (20) step();

        // long stall: output and skid fill, requests stop, then drain in order
        stall = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (k >= 4) chk_eq("stall_no_req", imem_req, 1'b0);
            step();
        end
        stall = 1'b0;
        repeat (10) step();

        // redirect while a slow fetch is in flight
        lat_min = 3; lat_max = 3;
        wait_grant("grant_before_redir", ga);
        step();
        do_redirect(32'h0000_0200);
        wait_valid_pc("redir_wait_pc", 32'h0000_0200);

        // redirect together with a response while stalled
        lat_min = 1; lat_max = 1;
        step();
        wait_grant("grant_before_redir2", ga);
        step();
        stall = 1'b1;
        do_redirect(32'h0000_0300);
        stall = 1'b0;
        wait_valid_pc("redir2_wait_pc", 32'h0000_0300);

        // sequential fetch across the top of the address space
        step();
        do_redirect(32'hFFFF_FFF8);
        wait_grant("wrap_g0", ga);
        chk_eq("wrap_addr0", ga, 32'hFFFF_FFF8);
        wait_grant("wrap_g1", ga);
        chk_eq("wrap_addr1", ga, 32'hFFFF_FFFC);
        wait_grant("wrap_g2", ga);
        chk_eq("wrap_addr2", ga, 32'h0000_0000);
        repeat (6) step();

        // misaligned redirect target
        do_redirect(32'h0000_0102);
        wait_grant("mis_grant", ga);
        chk_eq("mis_addr", ga, 32'h0000_0100);
        repeat (10) step();

        // randomized traffic
        gnt_pct = 70; lat_min = 1; lat_max = 4;
        since = 0;
        for (int c = 0; c < 2500; c++) begin
            step();
            rst = 1'b0;
            redirect_valid = 1'b0;
            r = $urandom_range(999);
            if (r < 5) begin
                rst = 1'b1;
                load_stream(RV);
                since = 0;
            end else if (r < 45 || since > 120) begin
                redirect_valid = 1'b1;
                redirect_pc = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
                load_stream(exp_target(redirect_pc));
                since = 0;
            end else begin
                since++;
            end
            stall = ($urandom_range(99) < 30);
        end
        step();
        rst = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        repeat (30) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
